// File: rtl/mmio_fact_accel.sv
// Memory-mapped factorial accelerator on the MIPS data-memory port.
// Define FACT_IRQ_EN to add a completion interrupt output (irq).
module mmio_fact_accel #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
  parameter int unsigned N_MAX     = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
`ifdef FACT_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;

  logic        hit;
  logic [1:0]  offset;
  logic        wr;
  logic        go_wr;
  logic        status_wr;
  logic        done_set;
  logic        go_accept;
  logic        unused_bits;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = addr[3:2];
  assign wr          = we && hit;
  assign go_wr       = wr && (offset == 2'd1) && wd[0];
  assign status_wr   = wr && (offset == 2'd2);
  assign unused_bits = ^{addr[1:0], wd[31:4]};

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    result_d  = result_q;
    done_d    = done_q;
    err_d     = err_q;
    done_set  = 1'b0;
    go_accept = 1'b0;

    if (wr && (offset == 2'd0)) begin
      n_d = wd[3:0];
    end

    case (state_q)
      IDLE: begin
        if (go_wr) begin
          go_accept = 1'b1;
          if (32'(n_q) > N_MAX) begin
            err_d    = 1'b1;
            done_d   = 1'b1;
            result_d = 32'd0;
            done_set = 1'b1;
          end else begin
            err_d   = 1'b0;
            done_d  = 1'b0;
            prod_d  = 32'd1;
            cnt_d   = n_q;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // cnt counts down to 1; N=0 falls straight through with prod=1
        if (cnt_q > 4'd1) begin
          prod_d = prod_q * {28'd0, cnt_q};
          cnt_d  = cnt_q - 4'd1;
        end else begin
          result_d = prod_q;
          done_d   = 1'b1;
          done_set = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    irq_d = irq_q;
`ifdef FACT_IRQ_EN
    if (status_wr || go_accept) begin
      irq_d = 1'b0;
    end
    if (done_set) begin
      irq_d = 1'b1;
    end
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= 4'd0;
      cnt_q    <= 4'd0;
      prod_q   <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rd = 32'd0;
    if (hit) begin
      case (offset)
        2'd0:    rd = {28'd0, n_q};
        2'd1:    rd = {31'd0, (state_q == BUSY)};
        2'd2:    rd = {30'd0, err_q, done_q};
        default: rd = result_q;
      endcase
    end
  end

`ifdef FACT_IRQ_EN
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_q, irq_d, status_wr, go_accept};
`endif

endmodule

// File: tb/tb_mmio_fact_accel.sv
// Self-checking bench for mmio_fact_accel: table-driven factorial runs plus
// hand-written sequences for GO-while-busy, mid-run reset and the irq option.
module tb_mmio_fact_accel;

  localparam logic [31:0] BASE = 32'h0000_0800;
  localparam logic [31:0] PARK = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
`ifdef FACT_IRQ_EN
  logic        irq;
`endif

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [31:0] result;
    logic [31:0] status;
  } exp_t;
  exp_t scoreboard[$];

  typedef struct {
    logic [31:0] n;
    logic [31:0] expResult;
    logic [31:0] expStatus;
    int          expLatency;
  } vec_t;
  vec_t vecs[8];

  typedef struct {
    logic [31:0] a;
    logic [31:0] expRd;
  } rdvec_t;
  rdvec_t resetReads[6];

  mmio_fact_accel dut (
`ifdef FACT_IRQ_EN
    .irq  (irq),
`endif
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .rd   (rd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One store: the write lands on the next rising edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    wd   = d;
    tick();
    we   = 1'b0;
    addr = PARK;
    wd   = 32'd0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd;
  endtask

  task automatic waitDone(output int cycles);
    logic [31:0] s;
    cycles = 0;
    busRead(BASE + 32'h8, s);
    while (s[0] !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
      busRead(BASE + 32'h8, s);
    end
  endtask

  task automatic compareScoreboard(input string tag);
    exp_t        e;
    logic [31:0] r;
    if (scoreboard.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = scoreboard.pop_front();
    busRead(BASE + 32'hC, r);
    checkOutput({tag, " RESULT"}, r, e.result);
    busRead(BASE + 32'h8, r);
    checkOutput({tag, " STATUS"}, r, e.status);
    busRead(BASE + 32'h4, r);
    checkOutput({tag, " busy idle"}, r, 32'd0);
  endtask

  task automatic runVector(input vec_t v, input int idx);
    logic [31:0] r;
    int          cycles;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    applyStimulus(BASE, v.n);
    scoreboard.push_back('{v.expResult, v.expStatus});
    applyStimulus(BASE + 32'h4, 32'd1);
    busRead(BASE + 32'h4, r);
    checkOutput({tag, " busy after GO"}, r, (v.expStatus == 32'd1) ? 32'd1 : 32'd0);
    waitDone(cycles);
    checkOutput({tag, " latency"}, 32'(cycles), 32'(v.expLatency));
    compareScoreboard(tag);
  endtask

  initial begin
    logic [31:0] r;
    int          cycles;

    vecs[0] = '{32'd5,          32'd120,       32'd1, 5};
    vecs[1] = '{32'd12,         32'd479001600, 32'd1, 12};
    vecs[2] = '{32'd0,          32'd1,         32'd1, 1};
    vecs[3] = '{32'd1,          32'd1,         32'd1, 1};
    vecs[4] = '{32'd13,         32'd0,         32'd3, 0};
    vecs[5] = '{32'd3,          32'd6,         32'd1, 3};
    vecs[6] = '{32'd15,         32'd0,         32'd3, 0};
    vecs[7] = '{32'hABCD_0007,  32'd5040,      32'd1, 7};

    resetReads[0] = '{BASE,            32'd0};
    resetReads[1] = '{BASE + 32'h4,    32'd0};
    resetReads[2] = '{BASE + 32'h8,    32'd0};
    resetReads[3] = '{BASE + 32'hC,    32'd0};
    resetReads[4] = '{32'h0000_0900,   32'd0};
    resetReads[5] = '{BASE + 32'hF,    32'd0};

    rst  = 1'b1;
    we   = 1'b0;
    addr = PARK;
    wd   = 32'd0;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      busRead(resetReads[i].a, r);
      checkOutput($sformatf("reset read %08h", resetReads[i].a), r, resetReads[i].expRd);
    end
`ifdef FACT_IRQ_EN
    checkOutput("reset irq", {31'd0, irq}, 32'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      runVector(vecs[i], i);
    end
    busRead(BASE, r);
    checkOutput("N upper bits dropped", r, 32'd7);

    // GO at E2 and N write at E3 must not disturb a running N=6
    applyStimulus(BASE, 32'd6);
    scoreboard.push_back('{32'd720, 32'd1});
    applyStimulus(BASE + 32'h4, 32'd1);
    tick();
    applyStimulus(BASE + 32'h4, 32'd1);
    applyStimulus(BASE, 32'd2);
    waitDone(cycles);
    checkOutput("busy GO latency", 32'(cycles + 3), 32'd6);
    compareScoreboard("busy GO");
    busRead(BASE, r);
    checkOutput("N written while busy", r, 32'd2);

    applyStimulus(BASE + 32'hC, 32'hDEAD_BEEF);
    applyStimulus(BASE + 32'h8, 32'd0);
    busRead(BASE + 32'hC, r);
    checkOutput("RESULT write ignored", r, 32'd720);
    busRead(BASE + 32'h8, r);
    checkOutput("STATUS write ignored", r, 32'd1);

    applyStimulus(BASE + 32'h4, 32'hFFFF_FFFE);
    busRead(BASE + 32'h4, r);
    checkOutput("GO bit0=0 busy", r, 32'd0);
    busRead(BASE + 32'h8, r);
    checkOutput("GO bit0=0 status", r, 32'd1);

    applyStimulus(32'h0000_0900, 32'd9);
    busRead(BASE, r);
    checkOutput("miss write N", r, 32'd2);

    // Reset at E3 of an N=6 run
    applyStimulus(BASE, 32'd6);
    applyStimulus(BASE + 32'h4, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busRead(BASE, r);
    checkOutput("midrst N", r, 32'd0);
    busRead(BASE + 32'h4, r);
    checkOutput("midrst busy", r, 32'd0);
    busRead(BASE + 32'h8, r);
    checkOutput("midrst STATUS", r, 32'd0);
    busRead(BASE + 32'hC, r);
    checkOutput("midrst RESULT", r, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    busRead(BASE + 32'h8, r);
    checkOutput("midrst no done", r, 32'd0);

`ifdef FACT_IRQ_EN
    applyStimulus(BASE, 32'd4);
    applyStimulus(BASE + 32'h4, 32'd1);
    checkOutput("irq low while busy", {31'd0, irq}, 32'd0);
    waitDone(cycles);
    checkOutput("irq N=4 latency", 32'(cycles), 32'd4);
    checkOutput("irq on done", {31'd0, irq}, 32'd1);
    applyStimulus(BASE + 32'h8, 32'h1234_5678);
    checkOutput("irq cleared by STATUS write", {31'd0, irq}, 32'd0);

    // STATUS write lands on the completion edge E2 of N=2: set wins
    applyStimulus(BASE, 32'd2);
    applyStimulus(BASE + 32'h4, 32'd1);
    tick();
    applyStimulus(BASE + 32'h8, 32'd0);
    checkOutput("irq set wins", {31'd0, irq}, 32'd1);
    busRead(BASE + 32'hC, r);
    checkOutput("irq N=2 RESULT", r, 32'd2);

    applyStimulus(BASE, 32'd3);
    applyStimulus(BASE + 32'h4, 32'd1);
    checkOutput("irq cleared by GO", {31'd0, irq}, 32'd0);
    waitDone(cycles);
    checkOutput("irq after N=3", {31'd0, irq}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
